// File: rtl/fir_mac_engine.sv
// Handshaked N-tap FIR engine: delay line, coefficient RAM and a two-stage multiply/accumulate.
// Define MAC_SAT_EN to clamp out_data on overflow; by default the result wraps.
module fir_mac_engine #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ACC_W     = 40,
  parameter int unsigned TAPS      = 8,
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [DATA_W-1:0]         in_data,
  input  logic [$clog2(TAPS+1)-1:0] ntaps,
  input  logic                      coef_we,
  input  logic [$clog2(TAPS)-1:0]   coef_addr,
  input  logic [DATA_W-1:0]         coef_data,
  output logic                      busy,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_ovf
);

  localparam int unsigned NW = $clog2(TAPS + 1);
  localparam int unsigned AW = $clog2(TAPS);
  localparam int unsigned PW = 2 * DATA_W;

  typedef enum logic [1:0] {StIdle, StMac, StDrain, StOut} state_e;

  state_e                   state_q, state_d;
  logic signed [DATA_W-1:0] x_q [TAPS];
  logic signed [DATA_W-1:0] c_q [TAPS];
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [PW-1:0]     p_q, p_d;
  logic [NW-1:0]            i_q, i_d;
  logic [NW-1:0]            n_q, n_d;
  logic                     accept;
  logic                     coef_wr;
  logic [AW-1:0]            idx;

  assign idx = i_q[AW-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    p_d     = p_q;
    i_d     = i_q;
    n_d     = n_q;
    accept  = 1'b0;
    coef_wr = 1'b0;
    unique case (state_q)
      StIdle: begin
        coef_wr = coef_we && (32'(coef_addr) < TAPS);
        if (in_valid) begin
          accept  = 1'b1;
          n_d     = (ntaps == '0 || 32'(ntaps) > TAPS) ? NW'(TAPS) : ntaps;
          acc_d   = '0;
          p_d     = '0;
          i_d     = '0;
          state_d = StMac;
        end
      end
      StMac: begin
        // Product of tap i lands in p_q and is accumulated one edge later.
        p_d   = PW'(x_q[idx]) * PW'(c_q[idx]);
        acc_d = acc_q + ACC_W'(p_q);
        i_d   = i_q + NW'(1);
        if (i_q == n_q - NW'(1)) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        acc_d   = acc_q + ACC_W'(p_q);
        state_d = StOut;
      end
      StOut: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q <= '0;
      p_q   <= '0;
      i_q   <= '0;
      n_q   <= '0;
      for (int k = 0; k < TAPS; k++) begin
        x_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      acc_q <= acc_d;
      p_q   <= p_d;
      i_q   <= i_d;
      n_q   <= n_d;
      if (accept) begin
        x_q[0] <= in_data;
        for (int k = 1; k < TAPS; k++) begin
          x_q[k] <= x_q[k-1];
        end
      end
      if (coef_wr) begin
        c_q[coef_addr] <= coef_data;
      end
    end
  end

  logic signed [ACC_W-1:0]  y;
  logic [ACC_W-DATA_W:0]    y_hi;

  assign y        = acc_q >>> OUT_SHIFT;
  // Fits in DATA_W only when all bits from the output sign bit upward agree.
  assign y_hi     = y[ACC_W-1:DATA_W-1];
  assign out_ovf  = !((&y_hi) || !(|y_hi));

  assign in_ready  = (state_q == StIdle);
  assign busy      = !in_ready;
  assign out_valid = (state_q == StOut);

`ifdef MAC_SAT_EN
  always_comb begin
    if (!out_ovf) begin
      out_data = y[DATA_W-1:0];
    end else if (y[ACC_W-1]) begin
      out_data = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      out_data = {1'b0, {(DATA_W-1){1'b1}}};
    end
  end
`else
  assign out_data = y[DATA_W-1:0];
`endif

endmodule

// File: tb/tb_fir_mac_engine.sv
// Self-checking bench for fir_mac_engine: directed scenarios plus randomized traffic
// compared against a dot-product reference model.
module tb_fir_mac_engine;

  localparam int SH = 0;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  ntaps;
  logic        coef_we;
  logic [2:0]  coef_addr;
  logic [15:0] coef_data;
  logic        busy;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_ovf;

  int checks = 0;
  int errors = 0;

  // Reference state: sample history (newest first) and coefficient table.
  logic signed [15:0] m_x [8];
  logic signed [15:0] m_c [8];

  fir_mac_engine #(
    .DATA_W   (16),
    .ACC_W    (40),
    .TAPS     (8),
    .OUT_SHIFT(SH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .ntaps    (ntaps),
    .coef_we  (coef_we),
    .coef_addr(coef_addr),
    .coef_data(coef_data),
    .busy     (busy),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_ovf  (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int k = 0; k < 8; k++) begin
      m_x[k] = '0;
      m_c[k] = '0;
    end
  endtask

  function automatic void model_result(input int n, output logic [15:0] d, output logic ovf);
    longint acc;
    longint y;
    acc = 0;
    for (int k = 0; k < n; k++) acc += longint'(m_x[k]) * longint'(m_c[k]);
    y   = acc >>> SH;
    ovf = (y > 32767) || (y < -32768);
`ifdef MAC_SAT_EN
    if (y > 32767) d = 16'h7fff;
    else if (y < -32768) d = 16'h8000;
    else d = y[15:0];
`else
    d = y[15:0];
`endif
  endfunction

  task automatic coef_write(input logic [2:0] a, input logic [15:0] d);
    coef_we   = 1'b1;
    coef_addr = a;
    coef_data = d;
    tick();
    coef_we   = 1'b0;
    m_c[a]    = d;
  endtask

  // wr_mode: 0 none, 1 coefficient write on the accept edge, 2 write one edge into MAC.
  task automatic run_sample(input logic [15:0] s, input logic [3:0] nt, input int hold,
                            input int wr_mode, input logic [2:0] wa, input logic [15:0] wd,
                            output logic [15:0] got);
    int          n;
    int          cnt;
    logic [15:0] ed;
    logic        eo;
    check_eq("in_ready_before_accept", in_ready, 1);
    in_valid = 1'b1;
    in_data  = s;
    ntaps    = nt;
    if (wr_mode == 1) begin
      coef_we   = 1'b1;
      coef_addr = wa;
      coef_data = wd;
      m_c[wa]   = wd;
    end
    tick();
    in_valid = 1'b0;
    coef_we  = 1'b0;
    in_data  = 16'($urandom);
    ntaps    = 4'($urandom);
    n = (nt == 0 || nt > 8) ? 8 : int'(nt);
    for (int k = 7; k > 0; k--) m_x[k] = m_x[k-1];
    m_x[0] = s;
    model_result(n, ed, eo);
    cnt = 0;
    if (wr_mode == 2) begin
      check_eq("busy_in_mac", busy, 1);
      coef_we   = 1'b1;
      coef_addr = wa;
      coef_data = wd;
      tick();
      coef_we = 1'b0;
      cnt     = 1;
    end
    while (!out_valid && cnt < 40) begin
      tick();
      cnt++;
    end
    check_eq("latency", cnt, n + 1);
    check_eq("out_data", out_data, ed);
    check_eq("out_ovf", out_ovf, eo);
    got = out_data;
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_data  = 16'($urandom);
      tick();
      in_valid = 1'b0;
      check_eq("bp_valid", out_valid, 1);
      check_eq("bp_data", out_data, ed);
      check_eq("bp_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("idle_after_out", in_ready, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    clear_model();
  endtask

  initial begin
    logic [15:0] got;
    logic [15:0] s;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    ntaps     = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    out_ready = 1'b0;
    clear_model();
    tick();
    tick();
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_out_ovf", out_ovf, 0);
    reset = 1'b0;
    tick();
    check_eq("post_rst_in_ready", in_ready, 1);
    check_eq("post_rst_out_data", out_data, 0);

    // Basic FIR with coefficients 1..4
    for (int k = 0; k < 4; k++) coef_write(3'(k), 16'(k + 1));
    run_sample(16'd10, 4'd4, 0, 0, 3'd0, 16'd0, got);
    check_eq("fir_10", got, 10);
    run_sample(16'd20, 4'd4, 0, 0, 3'd0, 16'd0, got);
    check_eq("fir_40", got, 40);
    run_sample(16'd30, 4'd4, 0, 0, 3'd0, 16'd0, got);
    check_eq("fir_100", got, 100);
    run_sample(16'd40, 4'd4, 0, 0, 3'd0, 16'd0, got);
    check_eq("fir_200", got, 200);

    // Backpressure, then confirm the delay line ignored the held in_valid pulses
    run_sample(16'd50, 4'd4, 10, 0, 3'd0, 16'd0, got);
    run_sample(16'd7, 4'd4, 0, 0, 3'd0, 16'd0, got);
    check_eq("bp_delay_line", got, 16'd7 + 16'd100 + 16'd120 + 16'd120);

    // Saturation / wrap
    do_reset();
    coef_write(3'd0, 16'h7fff);
    coef_write(3'd1, 16'h7fff);
    run_sample(16'h7fff, 4'd2, 0, 0, 3'd0, 16'd0, got);
`ifdef MAC_SAT_EN
    check_eq("sat_data", got, 16'h7fff);
`else
    check_eq("wrap_data", got, 16'h0001);
`endif

    // Coefficient write while busy is dropped; in IDLE it lands, also on the accept edge
    run_sample(16'd1, 4'd1, 0, 2, 3'd0, 16'd100, got);
    run_sample(16'd1, 4'd1, 0, 0, 3'd0, 16'd0, got);
    check_eq("busy_wr_dropped", got, 16'h7fff);
    coef_write(3'd0, 16'd100);
    run_sample(16'd2, 4'd1, 0, 0, 3'd0, 16'd0, got);
    check_eq("idle_wr_taken", got, 200);
    run_sample(16'd3, 4'd1, 0, 1, 3'd0, 16'd5, got);
    check_eq("accept_edge_wr", got, 15);

    // Tap clamp: ntaps 9 and 0 both run 8 taps
    do_reset();
    for (int k = 0; k < 8; k++) coef_write(3'(k), 16'd1);
    for (int k = 1; k <= 8; k++) run_sample(16'(k), 4'd9, 0, 0, 3'd0, 16'd0, got);
    check_eq("clamp9_sum", got, 36);
    run_sample(16'd9, 4'd0, 0, 0, 3'd0, 16'd0, got);
    check_eq("clamp0_sum", got, 44);

    // Mid-run reset aborts immediately and clears coefficients
    in_valid = 1'b1;
    in_data  = 16'd77;
    ntaps    = 4'd8;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    #1;
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_busy", busy, 0);
    tick();
    reset = 1'b0;
    tick();
    clear_model();
    run_sample(16'd5, 4'd3, 0, 0, 3'd0, 16'd0, got);
    check_eq("post_abort_zero", got, 0);

    // Randomized traffic
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        coef_write(3'($urandom), ($urandom_range(0, 1) == 0) ? 16'($urandom) :
                   16'($signed(7'($urandom))));
      end
      s = ($urandom_range(0, 1) == 0) ? 16'($urandom) : 16'($signed(9'($urandom)));
      run_sample(s, 4'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(0, 2)),
                 3'($urandom), 16'($urandom), got);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_mac_engine.md
# fir_mac_engine

Parametrised, sequenced multiply-accumulate engine that runs an N-tap FIR dot product per input sample, replacing single-step T/P/accumulator MAC sequences with one handshaked block. It holds a sample delay line and a coefficient RAM. For each accepted sample it iterates a two-stage multiply/accumulate pipeline and presents a scaled, range-checked result on a valid/ready output. It sits between the data bus (sample source) and the data memory write path (result sink) of the DSP.

## Interface
- DATA_W, 16: sample, coefficient and result width; signed two's complement.
- ACC_W, 40: accumulator width; must be ≥ 2*DATA_W.
- TAPS, 8: maximum tap count and delay-line depth; must be ≥ 2.
- OUT_SHIFT, 15: arithmetic right shift applied to the accumulator before output.
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  sample present.
- in_ready  out  1  engine can accept a sample.
- in_data  in  DATA_W  sample.
- ntaps  in  $clog2(TAPS+1)  tap count, sampled on accept.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  $clog2(TAPS)  coefficient index.
- coef_data  in  DATA_W  coefficient value.
- busy  out  1  state is not IDLE.
- out_valid  out  1  result present.
- out_ready  in  1  sink accepts the result.
- out_data  out  DATA_W  scaled result.
- out_ovf  out  1  the scaled result did not fit in DATA_W.

## Operation
- FSM states: IDLE → MAC → DRAIN → OUT → IDLE.
- in_ready = (state == IDLE). busy = !in_ready. out_valid = (state == OUT).
- **Accept** (in_valid && in_ready on an edge):
  - Delay line shifts: x[0] ← in_data, x[k] ← x[k-1].
  - Latch N = ntaps, with 0 or values > TAPS replaced by TAPS.
  - acc ← 0, P ← 0, i ← 0, next state MAC.
- **MAC** (N cycles), per edge:
  - P ← x[i]*c[i] (full 2*DATA_W signed product).
  - acc ← acc + sext(P).
  - i ← i+1.
  - After the N-th edge, go to DRAIN.
- **DRAIN** (1 edge): acc ← acc + sext(P), then go to OUT.
- **Result**: y = acc >>> OUT_SHIFT.
  - out_ovf = 1 when y is outside [-2^(DATA_W-1), 2^(DATA_W-1)-1].
  - out_data is computed from y according to the Configuration section.
- **OUT**: out_valid, out_data and out_ovf are held stable until out_valid && out_ready on an edge, then go to IDLE.
- **Coefficients**:
  - A coef_we write is performed only when state is IDLE.
  - A write asserted in any other state is silently dropped.
  - A coef_addr value ≥ TAPS is dropped.
- The accumulator wraps modulo 2^ACC_W; no internal saturation.

## Timing
- **Reset**: while reset is high and after release:
  - state IDLE, in_ready 1, busy 0, out_valid 0, out_data 0, out_ovf 0.
  - acc, P, i, all x[k] and all c[k] are 0.
- Reset asserted mid-operation aborts immediately and asynchronously; the pending result is lost.
- **Latency**: accept on edge t → out_valid high after edge t+N+1.
- **Throughput**: the earliest next accept is on edge t+N+3, with out_ready held high.
- The output handshake edge and the next accept edge are never the same edge.
- in_valid is ignored while in_ready is 0. in_data and ntaps are sampled only on the accept edge.
- A coef_we write in IDLE on the same edge as an accept takes effect; the new c[addr] is used in that computation.

## Configuration
- MAC_SAT_EN defined:
  - out_data = y clamped to 2^(DATA_W-1)-1 or -2^(DATA_W-1) when out_ovf is 1.
  - Otherwise out_data = y[DATA_W-1:0].
- MAC_SAT_EN undefined:
  - out_data = y[DATA_W-1:0] always (wrap).
  - out_ovf is still computed and reported.

## Test plan
All scenarios use DATA_W=16, ACC_W=40, TAPS=8, OUT_SHIFT=0 unless stated.
- **Basic FIR**: c0..c3 = 1,2,3,4, ntaps=4, samples 10,20,30,40 → out_data 10, 40, 100, 200, out_ovf 0; out_valid rises 5 edges after each accept.
- **Saturation**: c0=c1=0x7FFF, ntaps=2, sample 0x7FFF → y=0x3FFF0001, out_ovf 1; out_data 0x7FFF with MAC_SAT_EN, 0x0001 without.
- **Backpressure**: hold out_ready=0 for 10 cycles in OUT → out_data and out_valid stable, in_ready 0, in_valid pulses ignored, delay line unchanged; out_ready=1 → IDLE next edge.
- **Coefficient write during busy**: write c0=100 during MAC → dropped; next sample uses the old c0; the same write in IDLE takes effect.
- **Tap clamp**: ntaps=0 and ntaps=9 with all c=1 → both use 8 taps; out_valid 9 edges after accept; out_data = sum of the last 8 samples.
- **Mid-run reset**: assert reset 2 cycles into MAC → out_valid 0 and in_ready 1 immediately; after release, sample 5 with any ntaps → out_data 0 (coefficients cleared).
